// File: rtl/ls_pkg.sv
// Shared definitions for the load/store execution pipe.
// Holds opcode encodings, the pipe FSM state type and the store-buffer entry layout.
package ls_pkg;

  // Width of the store-buffer entry fields; must equal the DATA_W of the pipe instance.
  localparam int unsigned LS_DATA_W = 16;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    LD_KILL
  } ls_state_e;

  typedef struct packed {
    logic [LS_DATA_W-1:0] addr;
    logic [LS_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/ls_store_buffer.sv
// Circular store buffer for the load/store pipe.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enq, enq_entry  push an {addr, data} entry (ignored when full)
//   deq           pop the head entry (ignored when empty)
//   query_addr    address compared against every valid entry
//   match         per-entry hit vector for query_addr
//   head          oldest entry
//   empty, full   occupancy flags
//   count         number of valid entries
module ls_store_buffer
  import ls_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(SB_DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq,
  input  sb_entry_t            enq_entry,
  input  logic                 deq,
  input  logic [LS_DATA_W-1:0] query_addr,
  output logic [SB_DEPTH-1:0]  match,
  output sb_entry_t            head,
  output logic                 empty,
  output logic                 full,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(SB_DEPTH);

  sb_entry_t               mem_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    enq_ok, deq_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DepthCnt);
  assign enq_ok = enq && !full;
  assign deq_ok = deq && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      match[i] = valid_q[i] && (mem_q[i].addr == query_addr);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because SB_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (enq_ok) begin
        mem_q[wr_ptr_q]   <= enq_entry;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (deq_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ls_pipe_unit.sv
// Load/store execution pipe between the load/store reservation station and the CDB.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         kills the in-flight load and any pending CDB result
//   iss_*                         issue handshake and operands from the reservation station
//   mem_req_*                     memory request handshake (we = 1 for store drains)
//   mem_rsp_valid, mem_rsp_data   load response
//   cdb_*                         result register with valid/ready handshake
//   sb_count                      store buffer occupancy
module ls_pipe_unit
  import ls_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        iss_valid,
  output logic                        iss_ready,
  input  logic [DATA_W-1:0]           iss_pc,
  input  logic [3:0]                  iss_opcode,
  input  logic [DATA_W-1:0]           iss_base,
  input  logic [DATA_W-1:0]           iss_offset,
  input  logic [DATA_W-1:0]           iss_data,
  input  logic [TAG_W-1:0]            iss_tag,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [DATA_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_W-1:0]           mem_rsp_data,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [DATA_W-1:0]           cdb_pc,
  output logic [DATA_W-1:0]           cdb_pc_next,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [3:0]                  cdb_opcode,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic                        cdb_zero,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  ls_state_e              state_q, state_d;
  logic [DATA_W-1:0]      ld_pc_q, ld_addr_q;
  logic [TAG_W-1:0]       ld_tag_q;

  logic                   cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]      cdb_pc_q, cdb_pc_d;
  logic [DATA_W-1:0]      cdb_pc_next_q, cdb_pc_next_d;
  logic [DATA_W-1:0]      cdb_data_q, cdb_data_d;
  logic [3:0]             cdb_opcode_q, cdb_opcode_d;
  logic [TAG_W-1:0]       cdb_tag_q, cdb_tag_d;
  logic                   cdb_zero_q, cdb_zero_d;

  logic [DATA_W-1:0]      iss_addr;
  logic                   accept, is_lw, is_sw;
  logic                   ld_req, st_req, ld_done;
  logic                   sb_enq, sb_deq, sb_empty, sb_full;
  logic [SB_DEPTH-1:0]    sb_match;
  sb_entry_t              sb_head, sb_new;

  assign iss_addr = iss_base + iss_offset;
  assign is_lw    = (iss_opcode == OP_LW);
  assign is_sw    = (iss_opcode == OP_SW);

  assign iss_ready = (state_q == IDLE) && !cdb_valid_q && !flush && (!is_sw || !sb_full);
  assign accept    = iss_valid && iss_ready;

  // A load may not pass a buffered store to the same address.
  assign ld_req  = (state_q == LD_REQ) && !(|sb_match) && !flush;
  // Stores drain whenever the load does not own the port and no load response is outstanding.
  assign st_req  = !ld_req && !sb_empty && (state_q != LD_WAIT) && (state_q != LD_KILL);
  assign ld_done = (state_q == LD_WAIT) && mem_rsp_valid && !flush;

  assign sb_enq      = accept && is_sw;
  assign sb_deq      = st_req && mem_req_ready;
  assign sb_new.addr = iss_addr;
  assign sb_new.data = iss_data;

  ls_store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk        (clk),
    .rst        (rst),
    .enq        (sb_enq),
    .enq_entry  (sb_new),
    .deq        (sb_deq),
    .query_addr (ld_addr_q),
    .match      (sb_match),
    .head       (sb_head),
    .empty      (sb_empty),
    .full       (sb_full),
    .count      (sb_count)
  );

  always_comb begin
    mem_req_valid = ld_req || st_req;
    mem_req_we    = st_req;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (ld_req) begin
      mem_req_addr = ld_addr_q;
    end else if (st_req) begin
      mem_req_addr  = sb_head.addr;
      mem_req_wdata = sb_head.data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_lw) state_d = LD_REQ;
      LD_REQ: begin
        if (flush) state_d = IDLE;
        else if (ld_req && mem_req_ready) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        // A response coinciding with flush is simply dropped; nothing further is owed.
        if (mem_rsp_valid) state_d = IDLE;
        else if (flush) state_d = LD_KILL;
      end
      LD_KILL: if (mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_pc_d      = cdb_pc_q;
    cdb_pc_next_d = cdb_pc_next_q;
    cdb_data_d    = cdb_data_q;
    cdb_opcode_d  = cdb_opcode_q;
    cdb_tag_d     = cdb_tag_q;
    cdb_zero_d    = cdb_zero_q;
    if (flush || (cdb_valid_q && cdb_ready)) begin
      cdb_valid_d   = 1'b0;
      cdb_pc_d      = '0;
      cdb_pc_next_d = '0;
      cdb_data_d    = '0;
      cdb_opcode_d  = '0;
      cdb_tag_d     = '0;
      cdb_zero_d    = 1'b0;
    end else if (ld_done) begin
      cdb_valid_d   = 1'b1;
      cdb_pc_d      = ld_pc_q;
      cdb_pc_next_d = ld_pc_q + DATA_W'(1);
      cdb_data_d    = mem_rsp_data;
      cdb_opcode_d  = OP_LW;
      cdb_tag_d     = ld_tag_q;
      cdb_zero_d    = (mem_rsp_data == '0);
    end else if (accept && is_sw) begin
      cdb_valid_d   = 1'b1;
      cdb_pc_d      = iss_pc;
      cdb_pc_next_d = iss_pc + DATA_W'(1);
      cdb_data_d    = '0;
      cdb_opcode_d  = OP_SW;
      cdb_tag_d     = iss_tag;
      cdb_zero_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ld_pc_q       <= '0;
      ld_addr_q     <= '0;
      ld_tag_q      <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_pc_q      <= '0;
      cdb_pc_next_q <= '0;
      cdb_data_q    <= '0;
      cdb_opcode_q  <= '0;
      cdb_tag_q     <= '0;
      cdb_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (accept && is_lw) begin
        ld_pc_q   <= iss_pc;
        ld_addr_q <= iss_addr;
        ld_tag_q  <= iss_tag;
      end
      cdb_valid_q   <= cdb_valid_d;
      cdb_pc_q      <= cdb_pc_d;
      cdb_pc_next_q <= cdb_pc_next_d;
      cdb_data_q    <= cdb_data_d;
      cdb_opcode_q  <= cdb_opcode_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_zero_q    <= cdb_zero_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_pc_next = cdb_pc_next_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_opcode  = cdb_opcode_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_zero    = cdb_zero_q;

endmodule

// File: doc/ls_pipe_unit.md
# ls_pipe_unit

Parametrised load/store execution pipe for the out-of-order core. It sits between the load/store reservation station and the CDB. Each accepted instruction computes a base+offset address. Stores are queued in an internal store buffer that drains to memory in the background. Loads run over a variable-latency memory request/response handshake, stall on address conflicts with buffered stores, and broadcast results on the CDB through a valid/ready register.

## Interface
- DATA_W, 16: data, address and PC width
- TAG_W, 5: RRF tag width
- SB_DEPTH, 4: store buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  kill in-flight load and pending CDB result
- iss_valid / iss_ready  in / out  1  issue handshake
- iss_pc  in  DATA_W  instruction PC
- iss_opcode  in  4  LW = 4'b0100, SW = 4'b0101
- iss_base, iss_offset  in  DATA_W  address operands
- iss_data  in  DATA_W  store data
- iss_tag  in  TAG_W  destination RRF tag
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_we  out  1  1 = store
- mem_req_addr, mem_req_wdata  out  DATA_W  request address and data
- mem_rsp_valid  in  1  load data valid
- mem_rsp_data  in  DATA_W  load data
- cdb_valid / cdb_ready  out / in  1  result handshake
- cdb_pc, cdb_pc_next, cdb_data  out  DATA_W  result fields
- cdb_opcode  out  4  result opcode
- cdb_tag  out  TAG_W  result tag
- cdb_zero  out  1  cdb_data == 0 (loads only; 0 for stores)
- sb_count  out  $clog2(SB_DEPTH)+1  store buffer occupancy

## Operation
- Address = iss_base + iss_offset, mod 2^DATA_W, for both LW and SW. pc_next = pc + 1, wraps.
- iss_ready = (state == IDLE) && !cdb_valid && !flush && (opcode != SW || sb_count < SB_DEPTH).
- Illegal opcode: accepted, then dropped. No CDB output, state unchanged.
- SW accept: the entry {addr, data} is enqueued. The CDB register loads {pc, pc+1, opcode, tag, data = 0, zero = 0} with cdb_valid = 1 on the next edge.
- LW accept: address and metadata are latched, then go to LD_REQ.
- FSM states:
  - IDLE
  - LD_REQ: if any valid buffer entry's address equals the load address, stay (conflict stall). Otherwise drive the load request with we = 0. On mem_req_ready, go to LD_WAIT.
  - LD_WAIT: on mem_rsp_valid, load the CDB register with data = rsp and zero = (rsp == 0), then go to IDLE.
  - LD_KILL: on mem_rsp_valid, discard the response and go to IDLE.
- Memory port arbitration: one request per cycle.
  - A non-conflicting load in LD_REQ wins.
  - Otherwise, when the buffer is non-empty and state ∉ {LD_WAIT, LD_KILL}, the buffer head is driven with we = 1. The head is dequeued on mem_req_ready.
  - Stores expect no response.
- CDB register holds until cdb_valid && cdb_ready, then clears.
- flush:
  - clears cdb_valid;
  - LD_REQ → IDLE (mem_req_valid for the load is gated off that cycle);
  - LD_WAIT → LD_KILL;
  - store buffer contents are untouched and keep draining.
- The store buffer is a circular FIFO. Pointers wrap at SB_DEPTH. Enqueue and dequeue may occur in the same cycle; count is unchanged in that case.

## Timing
- Reset: all outputs 0, FSM IDLE, buffer empty (sb_count = 0), pointers 0.
- SW: issue at edge N → cdb_valid after edge N+1. Earliest drain request from cycle N+1.
- LW, no conflict, zero-wait memory: accept at N → mem_req_valid in cycle N+1 → rsp in cycle N+2 → cdb_valid after edge N+2 (3-cycle issue-to-CDB).
- Conflict stall lasts until the matching entry has dequeued. The request is issued the cycle after the dequeue edge.
- Reset mid-operation: immediate return to reset state. Any outstanding memory response is ignored, since state = IDLE.

## Structure
- ls_pkg holds:
  - opcode constants OP_LW, OP_SW;
  - the FSM state enum {IDLE, LD_REQ, LD_WAIT, LD_KILL};
  - the store-buffer entry struct {addr, data}.
- Sub-module ls_store_buffer provides the FIFO, occupancy count, a per-entry address-match vector for a query address, and head outputs.

## Test plan
- Reset release with all inputs 0 → all outputs 0, iss_ready = 1, sb_count = 0.
- LW base = 16'h0010, offset = 16'h0004, memory returns 16'h0000 next cycle → mem_req_addr = 16'h0014; CDB data = 0, zero = 1, pc_next = pc + 1.
- Sequence:
  - SW base = 8, offset = 2, data = 16'hBEEF, with mem_req_ready = 0;
  - then LW to address 10 → load stalls in LD_REQ;
  - raise ready → store issues first, then the load;
  - rsp 16'hBEEF → CDB data 16'hBEEF.
- SB_DEPTH+1 SWs with mem_req_ready = 0 → iss_ready drops at sb_count = SB_DEPTH. Release ready → FIFO drains in order across the pointer wrap.
- LW in LD_WAIT, flush asserted, rsp arrives 2 cycles later → no cdb_valid, FSM back in IDLE, next LW completes normally.
- cdb_ready held 0 for 5 cycles after a result → CDB fields stable, iss_ready = 0 throughout, one transfer when ready rises.
